// File: rtl/axi_lite_mem_responder.sv
// AXI-Lite slave endpoint that turns lite reads/writes into single-port SRAM accesses.
// Reads and writes share the port through a round-robin arbiter; out-of-window accesses get SLVERR.
module axi_lite_mem_responder #(
    parameter int AddrWidth = 32,
    parameter int DataWidth = 32,
    parameter int MemWords  = 1024
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [AddrWidth-1:0]         aw_addr_i,
    input  logic [2:0]                   aw_prot_i,
    input  logic                         aw_valid_i,
    output logic                         aw_ready_o,
    input  logic [DataWidth-1:0]         w_data_i,
    input  logic [DataWidth/8-1:0]       w_strb_i,
    input  logic                         w_valid_i,
    output logic                         w_ready_o,
    output logic [1:0]                   b_resp_o,
    output logic                         b_valid_o,
    input  logic                         b_ready_i,
    input  logic [AddrWidth-1:0]         ar_addr_i,
    input  logic [2:0]                   ar_prot_i,
    input  logic                         ar_valid_i,
    output logic                         ar_ready_o,
    output logic [DataWidth-1:0]         r_data_o,
    output logic [1:0]                   r_resp_o,
    output logic                         r_valid_o,
    input  logic                         r_ready_i,
    output logic                         mem_req_o,
    output logic                         mem_we_o,
    output logic [$clog2(MemWords)-1:0]  mem_addr_o,
    output logic [DataWidth-1:0]         mem_wdata_o,
    output logic [DataWidth/8-1:0]       mem_be_o,
    input  logic [DataWidth-1:0]         mem_rdata_i
);

    localparam int StrbW = DataWidth / 8;
    localparam int OffW  = $clog2(StrbW);
    localparam int MemAw = $clog2(MemWords);
    localparam logic [AddrWidth:0] Limit = (AddrWidth + 1)'(MemWords * StrbW);
    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlvErr = 2'b10;

    logic                 r_aw_held;
    logic [AddrWidth-1:0] r_aw_addr;
    logic                 r_w_held;
    logic [DataWidth-1:0] r_w_data;
    logic [StrbW-1:0]     r_w_strb;
    logic                 r_ar_held;
    logic [AddrWidth-1:0] r_ar_addr;
    logic                 r_b_valid;
    logic [1:0]           r_b_resp;
    logic                 r_r_valid;
    logic [DataWidth-1:0] r_r_data;
    logic [1:0]           r_r_resp;
    logic                 r_rd_inflight;
    logic                 r_rr_wr;

    logic w_wr_elig;
    logic w_rd_elig;
    logic w_wr_gnt;
    logic w_rd_gnt;
    logic w_wr_err;
    logic w_rd_err;
    logic w_unused;

    assign w_unused = ^{aw_prot_i, ar_prot_i};

    assign aw_ready_o = ~r_aw_held;
    assign w_ready_o  = ~r_w_held;
    assign ar_ready_o = ~r_ar_held;

    assign w_wr_err = {1'b0, r_aw_addr} >= Limit;
    assign w_rd_err = {1'b0, r_ar_addr} >= Limit;

    assign w_wr_elig = r_aw_held & r_w_held & ~r_b_valid;
    assign w_rd_elig = r_ar_held & ~r_r_valid & ~r_rd_inflight;

    // r_rr_wr low gives the read side priority on a contested cycle
    assign w_wr_gnt = w_wr_elig & (~w_rd_elig | r_rr_wr);
    assign w_rd_gnt = w_rd_elig & (~w_wr_elig | ~r_rr_wr);

    assign mem_req_o   = (w_wr_gnt & ~w_wr_err) | (w_rd_gnt & ~w_rd_err);
    assign mem_we_o    = w_wr_gnt & ~w_wr_err;
    assign mem_addr_o  = w_wr_gnt ? r_aw_addr[OffW +: MemAw] : r_ar_addr[OffW +: MemAw];
    assign mem_wdata_o = r_w_data;
    assign mem_be_o    = r_w_strb;

    assign b_valid_o = r_b_valid;
    assign b_resp_o  = r_b_resp;

    // SRAM data is forwarded in its return cycle and registered if not taken
    assign r_valid_o = r_r_valid | r_rd_inflight;
    assign r_data_o  = r_rd_inflight ? mem_rdata_i : r_r_data;
    assign r_resp_o  = r_rd_inflight ? RespOkay : r_r_resp;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_aw_held     <= 1'b0;
            r_aw_addr     <= '0;
            r_w_held      <= 1'b0;
            r_w_data      <= '0;
            r_w_strb      <= '0;
            r_ar_held     <= 1'b0;
            r_ar_addr     <= '0;
            r_b_valid     <= 1'b0;
            r_b_resp      <= RespOkay;
            r_r_valid     <= 1'b0;
            r_r_data      <= '0;
            r_r_resp      <= RespOkay;
            r_rd_inflight <= 1'b0;
            r_rr_wr       <= 1'b0;
        end else begin
            if (aw_valid_i && aw_ready_o) begin
                r_aw_held <= 1'b1;
                r_aw_addr <= aw_addr_i;
            end else if (w_wr_gnt) begin
                r_aw_held <= 1'b0;
            end

            if (w_valid_i && w_ready_o) begin
                r_w_held <= 1'b1;
                r_w_data <= w_data_i;
                r_w_strb <= w_strb_i;
            end else if (w_wr_gnt) begin
                r_w_held <= 1'b0;
            end

            if (ar_valid_i && ar_ready_o) begin
                r_ar_held <= 1'b1;
                r_ar_addr <= ar_addr_i;
            end else if (w_rd_gnt) begin
                r_ar_held <= 1'b0;
            end

            if (w_wr_gnt) begin
                r_b_valid <= 1'b1;
                r_b_resp  <= w_wr_err ? RespSlvErr : RespOkay;
            end else if (b_ready_i) begin
                r_b_valid <= 1'b0;
            end

            r_rd_inflight <= w_rd_gnt & ~w_rd_err;

            if (w_rd_gnt && w_rd_err) begin
                r_r_valid <= 1'b1;
                r_r_data  <= '0;
                r_r_resp  <= RespSlvErr;
            end else if (r_rd_inflight) begin
                r_r_valid <= ~r_ready_i;
                r_r_data  <= mem_rdata_i;
                r_r_resp  <= RespOkay;
            end else if (r_ready_i) begin
                r_r_valid <= 1'b0;
            end

            if (w_wr_elig && w_rd_elig) begin
                r_rr_wr <= ~r_rr_wr;
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_mem_responder.sv
// Self-checking bench for axi_lite_mem_responder: directed table, corner sequences,
// and random single transactions against a byte-level memory model.
module tb_axi_lite_mem_responder;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] aw_addr = '0;
    logic        aw_valid = 1'b0;
    logic [31:0] w_data = '0;
    logic [3:0]  w_strb = '0;
    logic        w_valid = 1'b0;
    logic        b_ready = 1'b0;
    logic [31:0] ar_addr = '0;
    logic        ar_valid = 1'b0;
    logic        r_ready = 1'b0;
    logic [31:0] sram_rdata = '0;

    logic        aw_ready_o, w_ready_o, b_valid_o, ar_ready_o, r_valid_o;
    logic [1:0]  b_resp_o, r_resp_o;
    logic [31:0] r_data_o, mem_wdata_o;
    logic        mem_req_o, mem_we_o;
    logic [9:0]  mem_addr_o;
    logic [3:0]  mem_be_o;

    always #5 clk = ~clk;

    axi_lite_mem_responder #(
        .AddrWidth(AW), .DataWidth(DW), .MemWords(MW)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .aw_addr_i(aw_addr), .aw_prot_i(3'b000),
        .aw_valid_i(aw_valid), .aw_ready_o(aw_ready_o),
        .w_data_i(w_data), .w_strb_i(w_strb),
        .w_valid_i(w_valid), .w_ready_o(w_ready_o),
        .b_resp_o(b_resp_o), .b_valid_o(b_valid_o), .b_ready_i(b_ready),
        .ar_addr_i(ar_addr), .ar_prot_i(3'b000),
        .ar_valid_i(ar_valid), .ar_ready_o(ar_ready_o),
        .r_data_o(r_data_o), .r_resp_o(r_resp_o),
        .r_valid_o(r_valid_o), .r_ready_i(r_ready),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_be_o(mem_be_o), .mem_rdata_i(sram_rdata)
    );

    // SRAM with one cycle read latency plus an access log
    typedef struct {
        bit         we;
        logic [9:0] addr;
        logic [3:0] be;
        logic [31:0] wd;
        int         cyc;
    } mev_t;

    logic [31:0] smem [MW];
    mev_t        mlog[$];
    int          cyc = 0;

    always @(posedge clk) begin
        if (mem_req_o) begin
            mlog.push_back('{mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o, cyc});
            if (mem_we_o) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_be_o[b]) smem[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
                end
            end else begin
                sram_rdata <= smem[mem_addr_o];
            end
        end
        cyc = cyc + 1;
    end

    // Reference model: byte-addressed window of MW*4 bytes
    logic [31:0] ref_mem [MW];

    function automatic logic [1:0] m_write(logic [31:0] a, logic [31:0] d, logic [3:0] s);
        if (a >= 32'(MW * 4)) return 2'b10;
        for (int b = 0; b < 4; b++) begin
            if (s[b]) ref_mem[a[11:2]][8*b +: 8] = d[8*b +: 8];
        end
        return 2'b00;
    endfunction

    function automatic logic [33:0] m_read(logic [31:0] a);
        if (a >= 32'(MW * 4)) return {2'b10, 32'h0};
        return {2'b00, ref_mem[a[11:2]]};
    endfunction

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int hold, output logic [1:0] resp, output int lat,
                            output int t0);
        int n;
        bit stable;
        mlog.delete();
        @(negedge clk);
        aw_addr = a; aw_valid = 1'b1;
        w_data = d; w_strb = s; w_valid = 1'b1;
        n = 0;
        while (!(aw_ready_o && w_ready_o) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("wr_accept", n < 20, 1);
        @(negedge clk);
        aw_valid = 1'b0; w_valid = 1'b0;
        t0 = cyc;
        n = 1;
        while (!b_valid_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        lat = n;
        resp = b_resp_o;
        stable = 1'b1;
        repeat (hold) begin
            @(negedge clk);
            if (!b_valid_o || b_resp_o !== resp) stable = 1'b0;
        end
        b_ready = 1'b1;
        @(negedge clk);
        b_ready = 1'b0;
        chk("b_stable", stable, 1);
        chk("b_clear", b_valid_o, 0);
    endtask

    task automatic do_read(input logic [31:0] a, input int hold, output logic [31:0] data,
                           output logic [1:0] resp, output int lat, output int t0);
        int n;
        bit stable;
        mlog.delete();
        @(negedge clk);
        ar_addr = a; ar_valid = 1'b1;
        n = 0;
        while (!ar_ready_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rd_accept", n < 20, 1);
        @(negedge clk);
        ar_valid = 1'b0;
        t0 = cyc;
        n = 1;
        while (!r_valid_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        lat = n;
        data = r_data_o;
        resp = r_resp_o;
        stable = 1'b1;
        repeat (hold) begin
            @(negedge clk);
            if (!r_valid_o || r_data_o !== data || r_resp_o !== resp) stable = 1'b0;
        end
        r_ready = 1'b1;
        @(negedge clk);
        r_ready = 1'b0;
        chk("r_stable", stable, 1);
        chk("r_clear", r_valid_o, 0);
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
        int          exp_nreq;
        logic [9:0]  exp_maddr;
        logic [3:0]  exp_be;
        string       name;
    } vec_t;

    vec_t tbl[11];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  resp;
        logic [31:0] rdata;
        logic [33:0] mr;
        int          lat, t0;
        bit          ok, noreq;
        int          ac, wc, arc;
        bit          order[$];

        tbl[0]  = '{1'b1, 32'h10,       32'hDEADBEEF, 4'hF, 2'b00, 32'h0,        1, 10'd4,   4'hF, "wr_basic"};
        tbl[1]  = '{1'b0, 32'h10,       32'h0,        4'h0, 2'b00, 32'hDEADBEEF, 1, 10'd4,   4'h0, "rd_basic"};
        tbl[2]  = '{1'b1, 32'h20,       32'h11223344, 4'hF, 2'b00, 32'h0,        1, 10'd8,   4'hF, "wr_prefill"};
        tbl[3]  = '{1'b1, 32'h20,       32'hAABBCCDD, 4'h5, 2'b00, 32'h0,        1, 10'd8,   4'h5, "wr_partial"};
        tbl[4]  = '{1'b0, 32'h20,       32'h0,        4'h0, 2'b00, 32'h11BB33DD, 1, 10'd8,   4'h0, "rd_partial"};
        tbl[5]  = '{1'b1, 32'h1000,     32'h12345678, 4'hF, 2'b10, 32'h0,        0, 10'd0,   4'h0, "wr_oor"};
        tbl[6]  = '{1'b0, 32'hFFFFFFFC, 32'h0,        4'h0, 2'b10, 32'h0,        0, 10'd0,   4'h0, "rd_oor"};
        tbl[7]  = '{1'b1, 32'hFFC,      32'hCAFEF00D, 4'hF, 2'b00, 32'h0,        1, 10'h3FF, 4'hF, "wr_top"};
        tbl[8]  = '{1'b0, 32'hFFF,      32'h0,        4'h0, 2'b00, 32'hCAFEF00D, 1, 10'h3FF, 4'h0, "rd_top_unal"};
        tbl[9]  = '{1'b1, 32'h20,       32'hFFFFFFFF, 4'h0, 2'b00, 32'h0,        1, 10'd8,   4'h0, "wr_zero_strb"};
        tbl[10] = '{1'b0, 32'h23,       32'h0,        4'h0, 2'b00, 32'h11BB33DD, 1, 10'd8,   4'h0, "rd_after_zero"};

        for (int i = 0; i < MW; i++) begin
            smem[i] = '0;
            ref_mem[i] = '0;
        end

        // reset values
        repeat (2) @(negedge clk);
        chk("rst_readies", {aw_ready_o, w_ready_o, ar_ready_o}, 3'b111);
        chk("rst_valids", {b_valid_o, r_valid_o}, 2'b00);
        chk("rst_mem", {mem_req_o, mem_we_o}, 2'b00);
        chk("rst_payload", {b_resp_o, r_resp_o, r_data_o}, 36'h0);
        rst_n = 1'b1;

        // directed table
        foreach (tbl[i]) begin
            if (tbl[i].wr) begin
                do_write(tbl[i].addr, tbl[i].data, tbl[i].strb, i % 3, resp, lat, t0);
                void'(m_write(tbl[i].addr, tbl[i].data, tbl[i].strb));
            end else begin
                do_read(tbl[i].addr, i % 3, rdata, resp, lat, t0);
                chk({tbl[i].name, "_rdata"}, rdata, tbl[i].exp_rdata);
            end
            chk({tbl[i].name, "_resp"}, resp, tbl[i].exp_resp);
            chk({tbl[i].name, "_lat"}, lat, 2);
            chk({tbl[i].name, "_nreq"}, mlog.size(), tbl[i].exp_nreq);
            if (tbl[i].exp_nreq > 0 && mlog.size() > 0) begin
                chk({tbl[i].name, "_maddr"}, mlog[0].addr, tbl[i].exp_maddr);
                chk({tbl[i].name, "_we"}, mlog[0].we, tbl[i].wr);
                chk({tbl[i].name, "_mcyc"}, mlog[0].cyc, t0);
                if (tbl[i].wr) begin
                    chk({tbl[i].name, "_be"}, mlog[0].be, tbl[i].exp_be);
                    chk({tbl[i].name, "_wdata"}, mlog[0].wd, tbl[i].data);
                end
            end
        end

        // W before AW, then B held off while a second write waits
        @(negedge clk);
        w_data = 32'h0BADF00D; w_strb = 4'hF; w_valid = 1'b1;
        aw_addr = 32'h30;
        chk("wfirst_rdy0", {aw_ready_o, w_ready_o}, 2'b11);
        @(negedge clk);
        w_valid = 1'b0;
        chk("wfirst_rdy1", {aw_ready_o, w_ready_o}, 2'b10);
        chk("wfirst_noreq", mem_req_o, 0);
        aw_valid = 1'b1;
        @(negedge clk);
        aw_valid = 1'b0;
        chk("wfirst_req", {mem_req_o, mem_we_o, mem_addr_o}, {2'b11, 10'd12});
        @(negedge clk);
        chk("wfirst_b", {b_valid_o, b_resp_o}, 3'b100);
        chk("wsecond_rdy", {aw_ready_o, w_ready_o}, 2'b11);
        aw_addr = 32'h34; w_data = 32'h600DCAFE; aw_valid = 1'b1; w_valid = 1'b1;
        ok = 1'b1; noreq = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 0) begin
                aw_valid = 1'b0;
                w_valid = 1'b0;
            end
            if (!b_valid_o || b_resp_o !== 2'b00) ok = 1'b0;
            if (mem_req_o) noreq = 1'b0;
        end
        chk("bhold_stable", ok, 1);
        chk("bhold_noreq", noreq, 1);
        chk("bhold_held", {aw_ready_o, w_ready_o}, 2'b00);
        b_ready = 1'b1;
        @(negedge clk);
        b_ready = 1'b0;
        chk("wsecond_req", {b_valid_o, mem_req_o, mem_we_o, mem_addr_o}, {3'b011, 10'd13});
        @(negedge clk);
        chk("wsecond_b", b_valid_o, 1);
        b_ready = 1'b1;
        @(negedge clk);
        b_ready = 1'b0;
        void'(m_write(32'h30, 32'h0BADF00D, 4'hF));
        void'(m_write(32'h34, 32'h600DCAFE, 4'hF));

        // random single transactions against the model
        for (int k = 0; k < 80; k++) begin
            logic [31:0] a, d;
            logic [3:0]  s;
            int          h;
            if ($urandom_range(0, 9) == 0) a = $urandom_range(32'h1000, 32'hFFFFFFFF);
            else a = $urandom_range(0, 255);
            d = $urandom;
            s = 4'($urandom);
            h = $urandom_range(0, 2);
            if ($urandom_range(0, 1) == 1) begin
                do_write(a, d, s, h, resp, lat, t0);
                chk("rnd_wr_resp", resp, m_write(a, d, s));
            end else begin
                do_read(a, h, rdata, resp, lat, t0);
                mr = m_read(a);
                chk("rnd_rd_resp", resp, mr[33:32]);
                chk("rnd_rd_data", rdata, mr[31:0]);
            end
            chk("rnd_lat", lat, 2);
        end

        // reset during an outstanding read
        @(negedge clk);
        ar_addr = 32'h10; ar_valid = 1'b1;
        @(negedge clk);
        ar_valid = 1'b0;
        chk("rstrd_memreq", mem_req_o, 1);
        rst_n = 1'b0;
        ok = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (r_valid_o) ok = 1'b0;
        end
        chk("rstrd_rdy_in_rst", {aw_ready_o, w_ready_o, ar_ready_o}, 3'b111);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (r_valid_o) ok = 1'b0;
        end
        chk("rstrd_no_rvalid", ok, 1);
        chk("rstrd_rdy_after", {aw_ready_o, w_ready_o, ar_ready_o}, 3'b111);
        do_read(32'h10, 1, rdata, resp, lat, t0);
        mr = m_read(32'h10);
        chk("rstrd_fresh_data", rdata, mr[31:0]);
        chk("rstrd_fresh_resp", resp, 2'b00);
        chk("rstrd_fresh_lat", lat, 2);

        // read and write streams contending from a fresh pointer
        ac = 0; wc = 0; arc = 0;
        b_ready = 1'b1; r_ready = 1'b1;
        for (int c = 0; c < 60 && order.size() < 8; c++) begin
            @(negedge clk);
            aw_valid = ac < 4;
            w_valid = wc < 4;
            ar_valid = arc < 4;
            aw_addr = 32'h100 + 32'(ac * 4);
            w_data = 32'(c);
            w_strb = 4'hF;
            ar_addr = 32'h100 + 32'(arc * 4);
            #1;
            if (aw_valid && aw_ready_o) ac++;
            if (w_valid && w_ready_o) wc++;
            if (ar_valid && ar_ready_o) arc++;
            if (mem_req_o) order.push_back(mem_we_o);
        end
        @(negedge clk);
        aw_valid = 1'b0; w_valid = 1'b0; ar_valid = 1'b0;
        repeat (3) @(negedge clk);
        b_ready = 1'b0; r_ready = 1'b0;
        chk("arb_count", order.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < order.size()) chk($sformatf("arb_grant%0d", i), order[i], (i % 2 == 1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
